// File: rtl/aead_ctrl_param.sv
// AEAD mode controller: sequences key/nonce loading, block absorb/output,
// tag generation or verification around an external permutation datapath.
module aead_ctrl_param #(
  parameter int KEY_WORDS  = 4,
  parameter int NPUB_WORDS = 4,
  parameter int BLK_WORDS  = 2,
  parameter int TAG_WORDS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_update,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       bdi_valid,
  input  logic       bdi_eot,
  input  logic       bdi_eoi,
  input  logic [3:0] bdi_type,
  input  logic [2:0] bdi_size,
  input  logic       decrypt,
  output logic       bdi_ready,
  output logic       bdo_valid,
  input  logic       bdo_ready,
  output logic [3:0] bdo_valid_bytes,
  output logic       end_of_block,
  output logic       perm_start,
  input  logic       perm_done,
  output logic       en_key,
  output logic       en_npub,
  output logic       en_bdi,
  output logic       en_state,
  output logic       init_state,
  output logic       sel_tag,
  output logic [1:0] ctrl_word,
  output logic [3:0] word_idx,
  input  logic       tag_match,
  output logic       msg_auth_valid,
  output logic       msg_auth,
  input  logic       msg_auth_ready
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LD_KEY    = 4'd1;
  localparam logic [3:0] S_LD_NPUB   = 4'd2;
  localparam logic [3:0] S_INIT      = 4'd3;
  localparam logic [3:0] S_WAIT_INIT = 4'd4;
  localparam logic [3:0] S_LD_BLK    = 4'd5;
  localparam logic [3:0] S_WAIT_PERM = 4'd6;
  localparam logic [3:0] S_OUT_BLK   = 4'd7;
  localparam logic [3:0] S_TAG       = 4'd8;
  localparam logic [3:0] S_WAIT_TAG  = 4'd9;
  localparam logic [3:0] S_OUT_TAG   = 4'd10;
  localparam logic [3:0] S_LD_TAG    = 4'd11;
  localparam logic [3:0] S_VERIFY    = 4'd12;

  localparam logic [3:0] KEY_LAST  = 4'(KEY_WORDS - 1);
  localparam logic [3:0] NPUB_LAST = 4'(NPUB_WORDS - 1);
  localparam logic [3:0] BLK_LAST  = 4'(BLK_WORDS - 1);
  localparam logic [3:0] TAG_LAST  = 4'(TAG_WORDS - 1);

  logic [3:0] state, state_nxt;
  logic [3:0] cnt;
  logic       cnt_inc;
  logic       dec_r, eoi_r, eot_r, ad_r, blk_done;
  logic [3:0] last_idx;
  logic [2:0] last_size;
  logic       bdi_xfer;
  logic       blk_last;

  assign word_idx = cnt;
  assign bdi_xfer = bdi_valid & bdi_ready;
  assign blk_last = (cnt == BLK_LAST) | bdi_eot;

  always_comb begin
    state_nxt       = state;
    cnt_inc         = 1'b0;
    key_ready       = 1'b0;
    bdi_ready       = 1'b0;
    bdo_valid       = 1'b0;
    bdo_valid_bytes = 4'b1111;
    end_of_block    = 1'b0;
    perm_start      = 1'b0;
    en_key          = 1'b0;
    en_npub         = 1'b0;
    en_bdi          = 1'b0;
    en_state        = 1'b0;
    init_state      = 1'b0;
    sel_tag         = 1'b0;
    ctrl_word       = 2'b00;
    msg_auth_valid  = 1'b0;
    msg_auth        = 1'b0;
    case (state)
      S_IDLE: begin
        if (key_update && key_valid)       state_nxt = S_LD_KEY;
        else if (!key_update && bdi_valid) state_nxt = S_LD_NPUB;
      end
      S_LD_KEY: begin
        key_ready = key_valid;
        en_key    = key_valid;
        if (key_valid) begin
          if (cnt == KEY_LAST) state_nxt = S_LD_NPUB;
          else                 cnt_inc   = 1'b1;
        end
      end
      S_LD_NPUB: begin
        bdi_ready = 1'b1;
        en_npub   = bdi_valid;
        if (bdi_valid) begin
          if (cnt == NPUB_LAST) state_nxt = S_INIT;
          else                  cnt_inc   = 1'b1;
        end
      end
      S_INIT: begin
        init_state = 1'b1;
        en_state   = 1'b1;
        perm_start = 1'b1;
        state_nxt  = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (perm_done) begin
          en_state  = 1'b1;
          state_nxt = eoi_r ? S_TAG : S_LD_BLK;
        end
      end
      S_LD_BLK: begin
        // Block closes on the transfer; the permutation starts one cycle later.
        if (blk_done) begin
          perm_start = 1'b1;
          state_nxt  = S_WAIT_PERM;
        end else begin
          bdi_ready = 1'b1;
          en_bdi    = bdi_valid;
          if (bdi_valid && !blk_last) cnt_inc = 1'b1;
        end
      end
      S_WAIT_PERM: begin
        if (perm_done) begin
          if (!ad_r) state_nxt = S_OUT_BLK;
          else begin
            ctrl_word = 2'b01;
            en_state  = 1'b1;
            state_nxt = eoi_r ? S_TAG : S_LD_BLK;
          end
        end
      end
      S_OUT_BLK: begin
        bdo_valid = 1'b1;
        if ((cnt == last_idx) && eot_r) begin
          end_of_block = 1'b1;
          case (last_size)
            3'd1:    bdo_valid_bytes = 4'b1000;
            3'd2:    bdo_valid_bytes = 4'b1100;
            3'd3:    bdo_valid_bytes = 4'b1110;
            default: bdo_valid_bytes = 4'b1111;
          endcase
        end
        if (bdo_ready) begin
          if (cnt == last_idx) begin
            ctrl_word = 2'b10;
            en_state  = 1'b1;
            state_nxt = (eot_r || eoi_r) ? S_TAG : S_LD_BLK;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_TAG: begin
        perm_start = 1'b1;
        state_nxt  = S_WAIT_TAG;
      end
      S_WAIT_TAG: begin
        if (perm_done) state_nxt = dec_r ? S_LD_TAG : S_OUT_TAG;
      end
      S_OUT_TAG: begin
        sel_tag      = 1'b1;
        bdo_valid    = 1'b1;
        end_of_block = (cnt == TAG_LAST);
        if (bdo_ready) begin
          if (cnt == TAG_LAST) state_nxt = S_IDLE;
          else                 cnt_inc   = 1'b1;
        end
      end
      S_LD_TAG: begin
        bdi_ready = 1'b1;
        en_bdi    = bdi_valid;
        if (bdi_valid) begin
          if (cnt == TAG_LAST) state_nxt = S_VERIFY;
          else                 cnt_inc   = 1'b1;
        end
      end
      S_VERIFY: begin
        msg_auth_valid = 1'b1;
        msg_auth       = tag_match;
        if (msg_auth_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dec_r     <= 1'b0;
      eoi_r     <= 1'b0;
      eot_r     <= 1'b0;
      ad_r      <= 1'b0;
      blk_done  <= 1'b0;
      last_idx  <= '0;
      last_size <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt_inc)       cnt <= cnt + 4'd1;

      if (state_nxt != state)                         blk_done <= 1'b0;
      else if (state == S_LD_BLK && bdi_xfer && blk_last) blk_done <= 1'b1;

      if (state == S_IDLE) begin
        dec_r <= 1'b0;
        eoi_r <= 1'b0;
      end
      if (state == S_LD_NPUB && bdi_valid && cnt == NPUB_LAST) begin
        dec_r <= decrypt;
        eoi_r <= bdi_eoi;
      end
      // eoi is sticky so an early end-of-input still ends the message at segment end.
      if (state == S_LD_BLK && bdi_xfer) begin
        ad_r      <= (bdi_type == 4'b0001);
        eot_r     <= bdi_eot;
        last_size <= bdi_size;
        last_idx  <= cnt;
        if (bdi_eoi) eoi_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aead_ctrl_param.sv
// Bench for aead_ctrl_param: two instances (2/2 and 4/4 block/tag words), a
// vector table of messages, and an output-word scoreboard.
module tb_aead_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel;
  logic       key_update, key_valid, bdi_valid, bdi_eot, bdi_eoi, decrypt;
  logic [3:0] bdi_type;
  logic [2:0] bdi_size;
  logic       bdo_ready, tag_match, msg_auth_ready;
  logic       pd0, pd1;
  int         pc0, pc1;
  logic [22:0] o0, o1, o;

  logic       key_ready, bdi_ready, bdo_valid, eob, perm_start, en_key, en_state, sel_tag;
  logic       mav, ma;
  logic [3:0] mask, word_idx;
  logic [1:0] ctrl_word;

  aead_ctrl_param #(.KEY_WORDS(4), .NPUB_WORDS(4), .BLK_WORDS(2), .TAG_WORDS(2)) u0 (
    .clk(clk), .rst(rst),
    .key_update(key_update & ~sel), .key_valid(key_valid & ~sel), .key_ready(o0[22]),
    .bdi_valid(bdi_valid & ~sel), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
    .bdi_type(bdi_type), .bdi_size(bdi_size), .decrypt(decrypt), .bdi_ready(o0[21]),
    .bdo_valid(o0[20]), .bdo_ready(bdo_ready & ~sel), .bdo_valid_bytes(o0[19:16]),
    .end_of_block(o0[15]), .perm_start(o0[14]), .perm_done(pd0),
    .en_key(o0[13]), .en_npub(o0[12]), .en_bdi(o0[11]), .en_state(o0[10]),
    .init_state(o0[9]), .sel_tag(o0[8]), .ctrl_word(o0[7:6]), .word_idx(o0[5:2]),
    .tag_match(tag_match), .msg_auth_valid(o0[1]), .msg_auth(o0[0]),
    .msg_auth_ready(msg_auth_ready & ~sel)
  );

  aead_ctrl_param #(.KEY_WORDS(4), .NPUB_WORDS(4), .BLK_WORDS(4), .TAG_WORDS(4)) u1 (
    .clk(clk), .rst(rst),
    .key_update(key_update & sel), .key_valid(key_valid & sel), .key_ready(o1[22]),
    .bdi_valid(bdi_valid & sel), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
    .bdi_type(bdi_type), .bdi_size(bdi_size), .decrypt(decrypt), .bdi_ready(o1[21]),
    .bdo_valid(o1[20]), .bdo_ready(bdo_ready & sel), .bdo_valid_bytes(o1[19:16]),
    .end_of_block(o1[15]), .perm_start(o1[14]), .perm_done(pd1),
    .en_key(o1[13]), .en_npub(o1[12]), .en_bdi(o1[11]), .en_state(o1[10]),
    .init_state(o1[9]), .sel_tag(o1[8]), .ctrl_word(o1[7:6]), .word_idx(o1[5:2]),
    .tag_match(tag_match), .msg_auth_valid(o1[1]), .msg_auth(o1[0]),
    .msg_auth_ready(msg_auth_ready & sel)
  );

  assign o          = sel ? o1 : o0;
  assign key_ready  = o[22];
  assign bdi_ready  = o[21];
  assign bdo_valid  = o[20];
  assign mask       = o[19:16];
  assign eob        = o[15];
  assign perm_start = o[14];
  assign en_key     = o[13];
  assign en_state   = o[10];
  assign sel_tag    = o[8];
  assign ctrl_word  = o[7:6];
  assign word_idx   = o[5:2];
  assign mav        = o[1];
  assign ma         = o[0];

  // Permutation model: perm_done three cycles after perm_start.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin pc0 <= 0; pd0 <= 1'b0; end
    else begin
      pd0 <= (pc0 == 1);
      if (o0[14]) pc0 <= 3; else if (pc0 != 0) pc0 <= pc0 - 1;
    end
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin pc1 <= 0; pd1 <= 1'b0; end
    else begin
      pd1 <= (pc1 == 1);
      if (o1[14]) pc1 <= 3; else if (pc1 != 0) pc1 <= pc1 - 1;
    end
  end

  typedef struct {
    logic sel; logic key; logic dec;
    int nad; int npt; int lsz; logic tm;
    int exp_abs; int exp_bdo;
  } vec_t;

  int checks = 0, failures = 0;
  int key_cnt, abs_cnt, bdo_cnt;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] size_mask(input int s);
    case (s)
      1:       return 4'b1000;
      2:       return 4'b1100;
      3:       return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  // Scoreboard consumer: every accepted output word pops one expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (en_key) key_cnt++;
      if (ctrl_word == 2'b01 && en_state) abs_cnt++;
      if (bdo_valid && bdo_ready) begin
        bdo_cnt++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bdo_unexpected actual=%0h expected=none", {word_idx, mask, eob, sel_tag});
        end else begin
          check("bdo_word", {word_idx, mask, eob, sel_tag}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_key();
    logic ok = 1'b0;
    key_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (key_ready) begin ok = 1'b1; break; end
    end
    check("key_handshake", ok, 1'b1);
    if (ok) begin @(posedge clk); #1; end
    key_valid = 1'b0;
  endtask

  task automatic send_bdi(input logic [3:0] t, input logic eot, input logic eoi, input int sz);
    logic ok = 1'b0;
    bdi_valid = 1'b1; bdi_type = t; bdi_eot = eot; bdi_eoi = eoi; bdi_size = 3'(sz);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bdi_ready) begin ok = 1'b1; break; end
    end
    check("bdi_handshake", ok, 1'b1);
    if (ok) begin @(posedge clk); #1; end
    bdi_valid = 1'b0; bdi_eot = 1'b0; bdi_eoi = 1'b0;
  endtask

  task automatic run_msg(input vec_t v);
    int blk, tagw, mav_cycles;
    logic auth_seen;
    logic last;
    sel = v.sel;
    blk  = v.sel ? 4 : 2;
    tagw = v.sel ? 4 : 2;
    key_cnt = 0; abs_cnt = 0; bdo_cnt = 0;
    tag_match = v.tm;
    if (v.key) begin
      key_update = 1'b1;
      for (int i = 0; i < 4; i++) send_key();
      key_update = 1'b0;
      check("en_key_count", key_cnt, 4);
    end
    decrypt = v.dec;
    for (int i = 0; i < 4; i++)
      send_bdi(4'b1101, i == 3, (i == 3) && v.nad == 0 && v.npt == 0, 4);
    for (int i = 0; i < v.nad; i++)
      send_bdi(4'b0001, i == v.nad - 1, (i == v.nad - 1) && v.npt == 0, 4);
    for (int i = 0; i < v.npt; i++) begin
      last = (i == v.npt - 1);
      exp_q.push_back({4'(i % blk), last ? size_mask(v.lsz) : 4'b1111, last, 1'b0});
      send_bdi(4'b0100, last, last, last ? v.lsz : 4);
    end
    if (!v.dec) begin
      for (int i = 0; i < tagw; i++)
        exp_q.push_back({4'(i), 4'b1111, i == tagw - 1, 1'b1});
    end else begin
      for (int i = 0; i < tagw; i++)
        send_bdi(4'b1000, i == tagw - 1, i == tagw - 1, 4);
      mav_cycles = 0; auth_seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (!mav) begin
          if (mav_cycles > 0) break;
        end else begin
          mav_cycles++;
          auth_seen = ma;
          if (mav_cycles == 4) msg_auth_ready = 1'b1;
        end
      end
      msg_auth_ready = 1'b0;
      check("auth_valid_cycles", mav_cycles, 4);
      check("msg_auth", auth_seen, v.tm);
    end
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("outputs_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("ad_absorb_count", abs_cnt, v.exp_abs);
    check("bdo_word_count", bdo_cnt, v.exp_bdo);
    decrypt = 1'b0;
  endtask

  vec_t vecs[7];
  vec_t stall_v;
  int   stall_good;

  initial begin
    //           sel   key   dec  nad npt lsz tm   abs bdo
    vecs[0] = '{1'b0, 1'b1, 1'b0, 0, 0, 4, 1'b0, 0, 2};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1, 3, 2, 1'b0, 1, 5};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 0, 1, 3, 1'b1, 0, 1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 3, 2, 1, 1'b0, 2, 2};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 0, 5, 4, 1'b0, 0, 9};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 5, 0, 4, 1'b0, 2, 4};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 0, 0, 4, 1'b1, 0, 0};
    stall_v = '{1'b0, 1'b0, 1'b0, 0, 3, 4, 1'b0, 0, 5};

    rst = 1'b0; sel = 1'b0;
    key_update = 1'b0; key_valid = 1'b0; bdi_valid = 1'b0; bdi_eot = 1'b0; bdi_eoi = 1'b0;
    bdi_type = 4'b0000; bdi_size = 3'd4; decrypt = 1'b0;
    bdo_ready = 1'b1; tag_match = 1'b0; msg_auth_ready = 1'b0;
    #12;
    check("rst_outputs_u0", o0, 23'h0F0000);
    check("rst_outputs_u1", o1, 23'h0F0000);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_msg(vecs[i]);

    // Output back-pressure: hold bdo_ready low for 5 cycles of OUT_BLK.
    bdo_ready = 1'b0;
    stall_good = 0;
    fork
      run_msg(stall_v);
      begin
        logic seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
          @(negedge clk);
          if (bdo_valid) begin seen = 1'b1; break; end
        end
        if (seen) begin
          for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (bdo_valid && !en_state && !bdi_ready) stall_good++;
          end
        end
        @(posedge clk); #1;
        bdo_ready = 1'b1;
        check("stall_held_cycles", stall_good, 5);
      end
    join

    // Asynchronous reset while waiting on the permutation.
    sel = 1'b0;
    for (int i = 0; i < 4; i++) send_bdi(4'b1101, i == 3, 1'b0, 4);
    send_bdi(4'b0100, 1'b1, 1'b1, 4);
    @(posedge clk); #3;
    check("perm_pending_before_rst", pc0 != 0, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_async_wait_perm", o0, 23'h0F0000);
    @(negedge clk);
    check("rst_hold_outputs", o0, 23'h0F0000);
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_msg(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aead_ctrl_param.md
AEAD_CTRL_PARAM -- requirements
Module: aead_ctrl_param

Interface
REQ-001 SHALL have parameter KEY_WORDS, default 4, meaning 32-bit key words loaded per key update (1..16).
REQ-002 SHALL have parameter NPUB_WORDS, default 4, meaning 32-bit nonce words per message (1..16).
REQ-003 SHALL have parameter BLK_WORDS, default 2, meaning 32-bit words per AD/PT/CT block (1..16).
REQ-004 SHALL have parameter TAG_WORDS, default 2, meaning 32-bit tag words (1..16).
REQ-005 SHALL have ports, one per line:
  clk  in  1  clock
  rst  in  1  reset: asynchronous, active-low
  key_update, key_valid  in  1  key request / key word valid
  key_ready  out  1  key word accepted
  bdi_valid  in  1  data word valid
  bdi_eot, bdi_eoi  in  1  end of type / end of input
  bdi_type  in  4  segment type; 4'b0001 = AD
  bdi_size  in  3  valid bytes in word, 1..4
  decrypt  in  1  sampled with last nonce word
  bdi_ready  out  1  data word accepted
  bdo_valid  out  1  output word valid
  bdo_ready  in  1  output word accepted
  bdo_valid_bytes  out  4  byte mask, MSB = first byte
  end_of_block  out  1  last output word of segment
  perm_start  out  1  one-cycle permutation start pulse
  perm_done  in  1  permutation finished
  en_key, en_npub, en_bdi, en_state, init_state, sel_tag  out  1  datapath enables/selects
  ctrl_word  out  2  00 none, 01 absorb AD, 10 absorb PT/CT
  word_idx  out  4  current word index within key/npub/block/tag
  tag_match  in  1  datapath tag compare result
  msg_auth_valid, msg_auth  out  1  decrypt verdict valid / pass
  msg_auth_ready  in  1  verdict accepted

Function
REQ-006 SHALL implement states IDLE, LD_KEY, LD_NPUB, INIT, WAIT_INIT, LD_BLK, WAIT_PERM, OUT_BLK, TAG, WAIT_TAG, OUT_TAG, LD_TAG, VERIFY.
REQ-007 All handshakes are transfers on the cycle valid and ready are both 1. Ready/valid outputs are Moore or combinational from inputs. No combinational path bdo_ready->bdi_ready.
REQ-008 IDLE: key_update=1 and key_valid=1 -> LD_KEY. key_update=0 and bdi_valid=1 -> LD_NPUB. Otherwise stay.
REQ-009 LD_KEY: key_ready=key_valid, en_key=transfer, word_idx=counter. After KEY_WORDS transfers -> LD_NPUB, counter cleared.
REQ-010 LD_NPUB: bdi_ready=1, en_npub=transfer. On transfer NPUB_WORDS-1: capture decrypt, capture eoi flag from bdi_eoi, -> INIT.
REQ-011 INIT: single cycle; init_state=1, en_state=1, perm_start=1 -> WAIT_INIT.
REQ-012 WAIT_INIT: on perm_done: en_state=1. eoi flag=1 -> TAG, else -> LD_BLK.
REQ-013 LD_BLK: bdi_ready=1, en_bdi=transfer. Per transfer: store type (AD or not), word count, last bdi_size, eot/eoi flags.
REQ-014 LD_BLK exit: -> WAIT_PERM with perm_start=1 on the cycle after the BLK_WORDS-th transfer, or after a transfer with bdi_eot=1, whichever comes first.
REQ-015 Block with fewer than BLK_WORDS words: unloaded words SHALL be zero-padded by the datapath; controller asserts en_bdi only on real transfers.
REQ-016 WAIT_PERM: on perm_done -> OUT_BLK if non-AD, else absorb AD: ctrl_word=01, en_state=1, then -> TAG if eoi, else -> LD_BLK.
REQ-017 OUT_BLK: bdo_valid=1 for exactly the number of words loaded.
  - bdo_valid_bytes=1111, except last word of an eot block: size 1->1000, 2->1100, 3->1110, 4->1111.
  - end_of_block=1 on the last word when eot flag set.
  - After the last transfer: ctrl_word=10, en_state=1 -> TAG if eot or eoi, else -> LD_BLK.
REQ-018 TAG: perm_start=1 -> WAIT_TAG. On perm_done: -> LD_TAG if decrypt, else -> OUT_TAG.
REQ-019 OUT_TAG: sel_tag=1, bdo_valid=1, bdo_valid_bytes=1111. TAG_WORDS words, end_of_block on the last -> IDLE.
REQ-020 LD_TAG: bdi_ready=1, en_bdi=transfer. After TAG_WORDS transfers -> VERIFY.
REQ-021 VERIFY: msg_auth_valid=1, msg_auth=tag_match. On msg_auth_ready -> IDLE.
REQ-022 Word counter SHALL be 4-bit, clear on every state change and never exceed its word parameter minus 1.
REQ-023 Inputs ignored when not requested, e.g. bdi_valid during WAIT_PERM produces no bdi_ready.
REQ-024 bdi_eoi on a non-eot word SHALL be recorded and honoured at segment end.

Reset
REQ-025 rst=0 SHALL force IDLE, clear counter and flags, and drive all outputs 0 except bdo_valid_bytes=1111, regardless of clk.
REQ-026 rst low mid-operation: an interrupted handshake is abandoned, with no pending pulse after release. The first accepted action after rst rises is from IDLE.

Verification
REQ-027 Defaults; key_update=1, 4 key words, 4 npub words with decrypt=0 and bdi_eoi=1 -> key_ready x4, INIT, TAG, 2 tag words, end_of_block on word 2.
REQ-028 Encrypt, AD of 1 word with eot, PT of 3 words with last bdi_size=2 and eoi -> ctrl_word=01 once; outputs block 1 of 2 words, then block 2 of 1 word with mask 1100 and end_of_block; then 2 tag words.
REQ-029 Decrypt, 1 CT word, tag words with tag_match=1, msg_auth_ready held 0 for 3 cycles -> msg_auth_valid held 4 cycles, msg_auth=1, then IDLE.
REQ-030 bdo_ready=0 for 5 cycles in OUT_BLK -> bdo_valid held, no en_state, no bdi_ready until the block drains.
REQ-031 BLK_WORDS=4, TAG_WORDS=4, 5 PT words -> blocks of 4 and 1 words, 4 tag words.
REQ-032 rst=0 asserted in WAIT_PERM -> outputs 0 immediately; after release a new message runs as REQ-027.
